// File: rtl/fir_mac_param.sv
// Parametrised FIR multiply-accumulate. Operands are shifted in over one bus, and each accepted start yields one saturated result.
// Build option: define FIR_ROUND_EN to round half up before the output shift (default: truncate).
module fir_mac_param #(
   parameter int DATA_W    = 16,
   parameter int TAPS      = 16,
   parameter int LANES     = 4,
   parameter int OUT_SHIFT = 0,
   localparam int ACC_W    = 2*DATA_W + $clog2(TAPS)
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              wind,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   input  logic              signed_mode,
   input  logic              start,
   output logic              ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out,
   output logic [ACC_W-1:0]  out_full,
   output logic              sat_flag
);

   localparam int BEATS  = TAPS / LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int PROD_W = 2*DATA_W;

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, DONE} state_t;

   state_t              state_reg, state_next;
   logic [BEAT_W-1:0]   beat_reg, beat_next;
   logic                drain_reg, drain_next;
   logic                ready_c, mac_c, done_c, accept;

   logic                mode_reg;
   logic [DATA_W-1:0]   d_reg [TAPS];
   logic [DATA_W-1:0]   w_reg [TAPS];
   logic [DATA_W-1:0]   d_src [TAPS];
   logic [DATA_W-1:0]   w_src [TAPS];

   logic [PROD_W-1:0]   prod_c   [LANES];
   logic [PROD_W-1:0]   prod_reg [LANES];
   logic                s1_vld_reg, s2_vld_reg;
   logic [ACC_W-1:0]    sum_c, sum_reg, acc_reg;

   logic [ACC_W:0]      acc_x, acc_r, shifted;
   logic                fits_c, sat_c;
   logic [DATA_W-1:0]   out_c;

   logic                out_valid_reg, sat_reg;
   logic [DATA_W-1:0]   out_reg;
   logic [ACC_W-1:0]    out_full_reg;

   // ---------------- FSM ----------------
   always_ff @(negedge clk) begin
      if (rstb) begin
         state_reg <= IDLE;
         beat_reg  <= '0;
         drain_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         beat_reg  <= beat_next;
         drain_reg <= drain_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      beat_next  = beat_reg;
      drain_next = drain_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = MAC;
               beat_next  = '0;
            end
         end
         MAC: begin
            if (beat_reg == BEAT_W'(BEATS-1)) begin
               beat_next  = '0;
               drain_next = 1'b0;
               state_next = DRAIN;
            end else begin
               beat_next = beat_reg + BEAT_W'(1);
            end
         end
         DRAIN: begin
            drain_next = ~drain_reg;
            if (drain_reg) state_next = DONE;
         end
         DONE: begin
            if (start) begin
               state_next = MAC;
               beat_next  = '0;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready_c = (state_reg == IDLE) || (state_reg == DONE);
      mac_c   = (state_reg == MAC);
      done_c  = (state_reg == DONE);
      accept  = start && ready_c;
   end

   // ---------------- operand chains ----------------
   always_ff @(negedge clk) begin
      if (rstb) mode_reg <= 1'b0;
      else if (accept) mode_reg <= signed_mode;
   end

   generate
      for (genvar gi = 0; gi < TAPS; gi++) begin : tap_g
         if (gi == 0) begin : head_g
            assign d_src[gi] = data;
            assign w_src[gi] = data;
         end else begin : link_g
            assign d_src[gi] = d_reg[gi-1];
            assign w_src[gi] = w_reg[gi-1];
         end

         // Shifts are only honoured while ready, so operands stay frozen during MAC/DRAIN.
         always_ff @(negedge clk) begin
            if (rstb) begin
               d_reg[gi] <= '0;
               w_reg[gi] <= '0;
            end else begin
               if (ready_c && load) d_reg[gi] <= d_src[gi];
               if (ready_c && wind) w_reg[gi] <= w_src[gi];
            end
         end
      end
   endgenerate

   // ---------------- stage 1: lane products ----------------
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : lane_g
         logic [TAP_W-1:0]  idx;
         logic [PROD_W-1:0] a_ext, b_ext;

         assign idx   = TAP_W'(int'(beat_reg) * LANES + gi);
         assign a_ext = {{DATA_W{mode_reg & d_reg[idx][DATA_W-1]}}, d_reg[idx]};
         assign b_ext = {{DATA_W{mode_reg & w_reg[idx][DATA_W-1]}}, w_reg[idx]};
         // Low 2*DATA_W bits of the extended product are exact in either mode.
         assign prod_c[gi] = a_ext * b_ext;

         always_ff @(negedge clk) begin
            if (rstb) prod_reg[gi] <= '0;
            else if (mac_c) prod_reg[gi] <= prod_c[gi];
         end
      end
   endgenerate

   // ---------------- stage 2: lane sum, stage 3: accumulate ----------------
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < LANES; i++) begin
         sum_c = sum_c + {{(ACC_W-PROD_W){mode_reg & prod_reg[i][PROD_W-1]}}, prod_reg[i]};
      end
   end

   always_ff @(negedge clk) begin
      if (rstb) begin
         s1_vld_reg <= 1'b0;
         s2_vld_reg <= 1'b0;
         sum_reg    <= '0;
         acc_reg    <= '0;
      end else begin
         s1_vld_reg <= mac_c;
         s2_vld_reg <= s1_vld_reg;
         if (s1_vld_reg) sum_reg <= sum_c;
         if (accept) acc_reg <= '0;
         else if (s2_vld_reg) acc_reg <= acc_reg + sum_reg;
      end
   end

   // ---------------- output scaling and saturation ----------------
`ifdef FIR_ROUND_EN
   localparam logic [ACC_W:0] RND =
      (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT-1 : 0)) : '0;
`endif

   always_comb begin
      acc_x = {mode_reg & acc_reg[ACC_W-1], acc_reg};
`ifdef FIR_ROUND_EN
      acc_r = acc_x + RND;
`else
      acc_r = acc_x;
`endif
      if (mode_reg) begin
         shifted = $signed(acc_r) >>> OUT_SHIFT;
         fits_c  = (&shifted[ACC_W:DATA_W-1]) | ~(|shifted[ACC_W:DATA_W-1]);
      end else begin
         shifted = acc_r >> OUT_SHIFT;
         fits_c  = ~(|shifted[ACC_W:DATA_W]);
      end
      sat_c = ~fits_c;
      if (fits_c)        out_c = shifted[DATA_W-1:0];
      else if (!mode_reg) out_c = '1;
      else if (shifted[ACC_W]) out_c = {1'b1, {(DATA_W-1){1'b0}}};
      else               out_c = {1'b0, {(DATA_W-1){1'b1}}};
   end

   // Results are captured while leaving DONE, so a back-to-back clear of acc_reg at the same edge is harmless.
   always_ff @(negedge clk) begin
      if (rstb) begin
         out_valid_reg <= 1'b0;
         out_reg       <= '0;
         out_full_reg  <= '0;
         sat_reg       <= 1'b0;
      end else begin
         out_valid_reg <= done_c;
         if (done_c) begin
            out_reg      <= out_c;
            out_full_reg <= acc_reg;
            sat_reg      <= sat_c;
         end
      end
   end

   assign ready     = ready_c;
   assign out_valid = out_valid_reg;
   assign out       = out_reg;
   assign out_full  = out_full_reg;
   assign sat_flag  = sat_reg;

endmodule

// File: tb/tb_fir_mac_param.sv
// Scoreboard bench for fir_mac_param: a default instance and an OUT_SHIFT=4 instance share one stimulus stream.
module tb_fir_mac_param;

   localparam int DW    = 16;
   localparam int TAPS  = 16;
   localparam int ACC_W = 36;
   localparam int LAT   = 7;
   localparam int OS1   = 4;
`ifdef FIR_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstb, wind, load, start, signed_mode;
   logic [DW-1:0] data;

   logic ready0, valid0, sat0, ready1, valid1, sat1;
   logic [DW-1:0] out0, out1;
   logic [ACC_W-1:0] full0, full1;

   always #5 clk = ~clk;

   fir_mac_param u_dut0 (
      .clk(clk), .rstb(rstb), .wind(wind), .load(load), .data(data),
      .signed_mode(signed_mode), .start(start), .ready(ready0),
      .out_valid(valid0), .out(out0), .out_full(full0), .sat_flag(sat0)
   );

   fir_mac_param #(.OUT_SHIFT(OS1)) u_dut4 (
      .clk(clk), .rstb(rstb), .wind(wind), .load(load), .data(data),
      .signed_mode(signed_mode), .start(start), .ready(ready1),
      .out_valid(valid1), .out(out1), .out_full(full1), .sat_flag(sat1)
   );

   typedef struct {
      logic [DW-1:0]    o;
      logic [ACC_W-1:0] f;
      logic             s;
      int               cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int checks = 0;
   int errors = 0;
   int pcyc   = 0;
   logic [DW-1:0] d_m [TAPS];
   logic [DW-1:0] w_m [TAPS];

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h required=%0h", tag, obs, expv);
      end
   endtask

   // Reference: full-precision sum, optional rounding, shift, clip.
   function automatic exp_t model(bit m, int os, int cyc);
      exp_t e;
      longint s, r, a, b;
      s = 0;
      for (int i = 0; i < TAPS; i++) begin
         a = m ? longint'($signed(d_m[i])) : longint'({48'b0, d_m[i]});
         b = m ? longint'($signed(w_m[i])) : longint'({48'b0, w_m[i]});
         s += a * b;
      end
      e.f = s[ACC_W-1:0];
      r = s;
      if (ROUND && os > 0) r += longint'(1) << (os - 1);
      r = r >>> os;
      if (m) begin
         if (r > 32767)       begin e.o = 16'h7FFF; e.s = 1'b1; end
         else if (r < -32768) begin e.o = 16'h8000; e.s = 1'b1; end
         else                 begin e.o = r[15:0];  e.s = 1'b0; end
      end else begin
         if (r > 65535)       begin e.o = 16'hFFFF; e.s = 1'b1; end
         else                 begin e.o = r[15:0];  e.s = 1'b0; end
      end
      e.cyc = cyc;
      return e;
   endfunction

   // Output monitor: samples on the rising edge, midway between state-update edges.
   always @(posedge clk) begin
      exp_t e;
      pcyc++;
      if (valid0 === 1'b1) begin
         checks++;
         assert (q0.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_valid0 observed out=%0h required no output", out0);
         end
         if (q0.size() > 0) begin
            e = q0.pop_front();
            $display("dut0 result: cyc=%0d out=%h full=%0d sat=%b", pcyc, out0, full0, sat0);
            chk("latency0", 64'(pcyc), 64'(e.cyc));
            chk("out0", 64'(out0), 64'(e.o));
            chk("out_full0", 64'(full0), 64'(e.f));
            chk("sat0", 64'(sat0), 64'(e.s));
         end
      end
      if (valid1 === 1'b1) begin
         checks++;
         assert (q1.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_valid1 observed out=%0h required no output", out1);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            $display("dut4 result: cyc=%0d out=%h full=%0d sat=%b", pcyc, out1, full1, sat1);
            chk("latency4", 64'(pcyc), 64'(e.cyc));
            chk("out4", 64'(out1), 64'(e.o));
            chk("out_full4", 64'(full1), 64'(e.f));
            chk("sat4", 64'(sat1), 64'(e.s));
         end
      end
   end

   task automatic shift_in(bit wd, bit ld, logic [DW-1:0] v);
      @(posedge clk); #1;
      wind = wd; load = ld; data = v;
      @(negedge clk); #1;
      wind = 1'b0; load = 1'b0;
      if (wd) begin
         for (int i = TAPS-1; i > 0; i--) w_m[i] = w_m[i-1];
         w_m[0] = v;
      end
      if (ld) begin
         for (int i = TAPS-1; i > 0; i--) d_m[i] = d_m[i-1];
         d_m[0] = v;
      end
   endtask

   task automatic fill(logic [DW-1:0] wv, bit same_data, logic [DW-1:0] dv);
      for (int i = 0; i < TAPS; i++) shift_in(1'b1, 1'b0, wv);
      for (int i = 1; i <= TAPS; i++) shift_in(1'b0, 1'b1, same_data ? dv : DW'(i));
   endtask

   task automatic start_op(bit m, bit keep, bit expect_out);
      int n;
      n = 0;
      @(posedge clk); #1;
      while (ready0 !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ready_wait", 64'(ready0), 64'(1));
      start = 1'b1;
      signed_mode = m;
      if (expect_out) begin
         q0.push_back(model(m, 0, pcyc + LAT + 1));
         q1.push_back(model(m, OS1, pcyc + LAT + 1));
      end
      $display("start: cyc=%0d mode=%b expect=%b", pcyc, m, expect_out);
      @(negedge clk); #1;
      if (!keep) start = 1'b0;
   endtask

   task automatic drain_q();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("queue_empty", 64'(q0.size() + q1.size()), 64'(0));
   endtask

   initial begin
      rstb = 1'b1; wind = 1'b0; load = 1'b0; start = 1'b0; signed_mode = 1'b0; data = '0;
      for (int i = 0; i < TAPS; i++) begin d_m[i] = '0; w_m[i] = '0; end

      // Reset state
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      chk("rst_ready", 64'(ready0), 64'(1));
      chk("rst_valid", 64'(valid0), 64'(0));
      chk("rst_out", 64'(out0), 64'(0));
      chk("rst_full", 64'(full0), 64'(0));
      chk("rst_sat", 64'(sat0), 64'(0));
      chk("rst_ready4", 64'(ready1), 64'(1));
      rstb = 1'b0;

      // Unsigned basic: weights 1, data 1..16 -> 136
      fill(16'd1, 1'b0, '0);
      start_op(1'b0, 1'b0, 1'b1);
      drain_q();

      // Signed/unsigned contrast with weights 0xFFFF
      fill(16'hFFFF, 1'b0, '0);
      start_op(1'b1, 1'b0, 1'b1);
      drain_q();
      start_op(1'b0, 1'b0, 1'b1);
      drain_q();

      // Signed positive saturation
      fill(16'h7FFF, 1'b1, 16'h7FFF);
      start_op(1'b1, 1'b0, 1'b1);
      drain_q();

      // Back-to-back with a load pulse during MAC that must be ignored
      fill(16'd1, 1'b0, '0);
      start_op(1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      load = 1'b1; data = 16'h1234;
      @(negedge clk); #1;
      load = 1'b0;
      start_op(1'b0, 1'b0, 1'b1);
      drain_q();

      // Reset during beat 2 abandons the computation
      start_op(1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rstb = 1'b1;
      @(negedge clk); #1;
      rstb = 1'b0;
      for (int i = 0; i < TAPS; i++) begin d_m[i] = '0; w_m[i] = '0; end
      repeat (12) @(posedge clk);
      #1;
      chk("midrst_ready", 64'(ready0), 64'(1));
      chk("midrst_full", 64'(full0), 64'(0));
      chk("midrst_queue", 64'(q0.size()), 64'(0));

      // Shifted output (instance with OUT_SHIFT=4): 136 -> 8 truncated, 9 rounded
      fill(16'd1, 1'b0, '0);
      start_op(1'b0, 1'b0, 1'b1);
      drain_q();
      start_op(1'b1, 1'b0, 1'b1);
      drain_q();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
